id_stage: RTL

Instruction decode stage of the RV32I core. It sits between fetch and the immediate generator / register-file read. It accepts one instruction and PC per valid/ready handshake, decodes the opcode into control fields, and presents them from a registered output with valid/ready handshake. Those control fields include the 3-bit immediate-format select consumed by the immediate generator. A one-entry skid buffer keeps `in_ready` registered, so backpressure never forms a combinational path back to fetch.

---
 rtl/rv_decode_pkg.sv | 54 +++++
 rtl/rv_inst_decoder.sv | 89 ++++++++
 rtl/id_stage.sv | 98 +++++++++
 3 files changed

// File: rtl/rv_decode_pkg.sv
// rtl/rv_decode_pkg.sv - RV32I decode encodings shared by id_stage and the immediate generator
package rv_decode_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_U = 3'b011,
      IMM_J = 3'b100
   } imm_sel_t;

   typedef enum logic [3:0] {
      CLS_LOAD    = 4'd0,
      CLS_STORE   = 4'd1,
      CLS_BRANCH  = 4'd2,
      CLS_JAL     = 4'd3,
      CLS_JALR    = 4'd4,
      CLS_OP_IMM  = 4'd5,
      CLS_OP      = 4'd6,
      CLS_LUI     = 4'd7,
      CLS_AUIPC   = 4'd8,
      CLS_FENCE   = 4'd9,
      CLS_SYSTEM  = 4'd10,
      CLS_ILLEGAL = 4'd11
   } opclass_t;

   typedef struct packed {
      logic [24:0] imm_fields;
      imm_sel_t    imm_sel;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic        funct7b5;
      opclass_t    opclass;
      logic        rd_we;
      logic        rs1_en;
      logic        rs2_en;
      logic        illegal;
   } decoded_t;

endpackage

// File: rtl/rv_inst_decoder.sv
// rtl/rv_inst_decoder.sv - combinational RV32I instruction word to decoded_t
module rv_inst_decoder
   import rv_decode_pkg::*;
(
   input  logic [31:0] instr,
   output decoded_t    dec
);

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic [4:0] rd;
   opclass_t   cls;
   imm_sel_t   sel;
   logic       bad;
   logic       we;
   logic       en1;
   logic       en2;

   assign opcode = instr[6:0];
   assign funct7 = instr[31:25];
   assign funct3 = instr[14:12];
   assign rd     = instr[11:7];

   always_comb begin
      cls = CLS_ILLEGAL;
      sel = IMM_I;
      bad = 1'b0;
      we  = 1'b0;
      en1 = 1'b0;
      en2 = 1'b0;
      case (opcode)
         OPC_LOAD:   begin cls = CLS_LOAD;   sel = IMM_I; we = 1'b1; en1 = 1'b1; end
         OPC_STORE:  begin cls = CLS_STORE;  sel = IMM_S; en1 = 1'b1; en2 = 1'b1; end
         OPC_BRANCH: begin
            cls = CLS_BRANCH; sel = IMM_B; en1 = 1'b1; en2 = 1'b1;
            bad = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         OPC_JAL:    begin cls = CLS_JAL;    sel = IMM_J; we = 1'b1; end
         OPC_JALR:   begin
            cls = CLS_JALR; sel = IMM_I; we = 1'b1; en1 = 1'b1;
            bad = (funct3 != 3'b000);
         end
         OPC_OP_IMM: begin
            cls = CLS_OP_IMM; sel = IMM_I; we = 1'b1; en1 = 1'b1;
            // SLLI takes only funct7 0; SRLI/SRAI take 0 or 0100000
            if (funct3 == 3'b001)
               bad = (funct7 != 7'b0000000);
            else if (funct3 == 3'b101)
               bad = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
         end
         OPC_OP:     begin
            cls = CLS_OP; sel = IMM_I; we = 1'b1; en1 = 1'b1; en2 = 1'b1;
            if (funct7 == 7'b0100000)
               bad = (funct3 != 3'b000) && (funct3 != 3'b101);
            else
               bad = (funct7 != 7'b0000000);
         end
         OPC_LUI:    begin cls = CLS_LUI;    sel = IMM_U; we = 1'b1; end
         OPC_AUIPC:  begin cls = CLS_AUIPC;  sel = IMM_U; we = 1'b1; end
         OPC_FENCE:  begin cls = CLS_FENCE;  sel = IMM_I; end
         OPC_SYSTEM: begin cls = CLS_SYSTEM; sel = IMM_I; end
         default:    bad = 1'b1;
      endcase
      if (instr[1:0] != 2'b11)
         bad = 1'b1;
      if (bad) begin
         cls = CLS_ILLEGAL;
         sel = IMM_I;
         we  = 1'b0;
         en1 = 1'b0;
         en2 = 1'b0;
      end
   end

   assign dec.imm_fields = instr[31:7];
   assign dec.imm_sel    = sel;
   assign dec.rs1        = instr[19:15];
   assign dec.rs2        = instr[24:20];
   assign dec.rd         = rd;
   assign dec.funct3     = funct3;
   assign dec.funct7b5   = instr[30];
   assign dec.opclass    = cls;
   assign dec.rd_we      = we && (rd != 5'd0);
   assign dec.rs1_en     = en1;
   assign dec.rs2_en     = en2;
   assign dec.illegal    = bad;

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage: registered output plus one-entry skid buffer
module id_stage
   import rv_decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [24:0]     out_imm_fields,
   output logic [2:0]      out_imm_sel,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [2:0]      out_funct3,
   output logic            out_funct7b5,
   output logic [3:0]      out_opclass,
   output logic            out_rd_we,
   output logic            out_rs1_en,
   output logic            out_rs2_en,
   output logic            out_illegal
);

   decoded_t        in_dec;
   decoded_t        out_dec;
   decoded_t        skid_dec;
   logic [XLEN-1:0] out_pc_q;
   logic [XLEN-1:0] skid_pc;
   logic            out_valid_q;
   logic            skid_valid;
   logic            accept;
   logic            out_free;

   rv_inst_decoder u_dec (
      .instr (in_instr),
      .dec   (in_dec)
   );

   assign accept   = in_valid && !skid_valid;
   // output slot can take new data when empty or being consumed this cycle
   assign out_free = !out_valid_q || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         skid_valid  <= 1'b0;
         out_dec     <= '0;
         out_pc_q    <= '0;
         skid_dec    <= '0;
         skid_pc     <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         skid_valid  <= 1'b0;
      end else if (out_free) begin
         // skid is only full while in_ready is low, so it never competes with a new input
         if (skid_valid) begin
            out_dec     <= skid_dec;
            out_pc_q    <= skid_pc;
            out_valid_q <= 1'b1;
            skid_valid  <= 1'b0;
         end else if (accept) begin
            out_dec     <= in_dec;
            out_pc_q    <= in_pc;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (accept) begin
         skid_dec   <= in_dec;
         skid_pc    <= in_pc;
         skid_valid <= 1'b1;
      end
   end

   assign in_ready       = !skid_valid;
   assign out_valid      = out_valid_q;
   assign out_pc         = out_pc_q;
   assign out_imm_fields = out_dec.imm_fields;
   assign out_imm_sel    = out_dec.imm_sel;
   assign out_rs1        = out_dec.rs1;
   assign out_rs2        = out_dec.rs2;
   assign out_rd         = out_dec.rd;
   assign out_funct3     = out_dec.funct3;
   assign out_funct7b5   = out_dec.funct7b5;
   assign out_opclass    = out_dec.opclass;
   assign out_rd_we      = out_dec.rd_we;
   assign out_rs1_en     = out_dec.rs1_en;
   assign out_rs2_en     = out_dec.rs2_en;
   assign out_illegal    = out_dec.illegal;

endmodule
